// File: rtl/hs32_fetch_if.sv
// Fetch-unit bus bundle: decode handshake (instd/pcd/reqd/ackd), memory read port and redirect.
// master = fetch unit; slave = decode/memory/execute side.
interface hs32_fetch_if;
   logic [31:0] instd;
   logic [31:0] pcd;
   logic        reqd;
   logic        ackd;
   logic [31:0] addr;
   logic        reqm;
   logic        ackm;
   logic [31:0] dtr;
   logic        flush;
   logic [31:0] newpc;

   modport master (
      output instd, pcd, ackd, addr, reqm,
      input  reqd, ackm, dtr, flush, newpc
   );

   modport slave (
      input  instd, pcd, ackd, addr, reqm,
      output reqd, ackm, dtr, flush, newpc
   );
endinterface

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch: one-outstanding memory reader feeding an in-order buffer toward decode.
// Define HS32_PREFETCH_EN for a FIFO_DEPTH-entry prefetch FIFO; otherwise a single-entry buffer.
module hs32_fetch #(
   parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   hs32_fetch_if.master bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

`ifdef HS32_PREFETCH_EN
   localparam int unsigned CAP = FIFO_DEPTH;
`else
   localparam int unsigned CAP = 1;
`endif
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [0:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic          wait_ack, ackd, push, pop, space_d;
   logic [31:0]   head_word, head_pc;

   assign wait_ack = (state_q == REQ) && !bus.ackm;
   assign ackd     = (count_q != '0) && !bus.flush;
   assign pop      = bus.reqd && ackd;
   // A word returned during a flush belongs to the abandoned path.
   assign push     = (state_q == REQ) && bus.ackm && !drop_q && !bus.flush;

   always_comb begin
      count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
      space_d = count_d < CW'(CAP);
   end

`ifdef HS32_PREFETCH_EN
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [31:0]   word_q [FIFO_DEPTH];
   logic [31:0]   wpc_q  [FIFO_DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;

   always_comb begin
      rd_d = rd_q;
      wr_d = wr_q;
      if (bus.flush) begin
         rd_d = '0;
         wr_d = '0;
      end else begin
         if (push) wr_d = wr_q + PW'(1);
         if (pop)  rd_d = rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q <= '0;
         wr_q <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            word_q[i] <= '0;
            wpc_q[i]  <= '0;
         end
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         if (push) begin
            word_q[wr_q] <= bus.dtr;
            wpc_q[wr_q]  <= addr_q;
         end
      end
   end

   assign head_word = word_q[rd_q];
   assign head_pc   = wpc_q[rd_q];
`else
   logic [31:0] word_q, wpc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= '0;
         wpc_q  <= '0;
      end else if (push) begin
         word_q <= bus.dtr;
         wpc_q  <= addr_q;
      end
   end

   assign head_word = word_q;
   assign head_pc   = wpc_q;
`endif

   // A request in flight is never withdrawn; a flush during it only marks its data for discard.
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if ((state_q == REQ) && bus.ackm) begin
         drop_d = 1'b0;
         if (!drop_q) pc_d = pc_q + 32'd4;
      end
      if (bus.flush) begin
         pc_d = bus.newpc & ~32'h3;
         if (wait_ack) drop_d = 1'b1;
      end
      if (wait_ack)
         state_d = REQ;
      else if (!bus.flush && space_d)
         state_d = REQ;
      else
         state_d = IDLE;
      addr_d = wait_ack ? addr_q : pc_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_VEC;
         addr_q  <= RESET_VEC;
         drop_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         drop_q  <= drop_d;
         count_q <= count_d;
      end
   end

   assign bus.ackd  = ackd;
   assign bus.instd = head_word;
   assign bus.pcd   = head_pc;
   assign bus.reqm  = (state_q == REQ);
   assign bus.addr  = addr_q;
endmodule

// File: tb/tb_hs32_fetch.sv
// Randomized bench for hs32_fetch: a transaction-level model predicts the decode stream,
// request addresses and buffer occupancy; directed scenarios pin the model with literal values.
module tb_hs32_fetch;
   localparam logic [31:0] RV  = 32'h0000_0100;
`ifdef HS32_PREFETCH_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif
   localparam int T6_OCC = (CAP >= 2) ? 2 : 1;

   logic clk;
   logic reset;

   hs32_fetch_if bus ();
   hs32_fetch_if bus2 ();

   hs32_fetch #(.RESET_VEC(RV), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   hs32_fetch #(.RESET_VEC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   // Second instance: zero-wait memory, decode always ready.
   assign bus2.ackm = bus2.reqm;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model state
   int          occ;
   logic [31:0] dec_pc, exp_addr, out_addr;
   logic        out, stale;
   int          acc_cnt, n_xfer;
   int          mem_cnt, lat, lat_min, lat_max;
   logic [31:0] req_q[$], xfer_q[$], req2_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.ackm  = bus.reqm && (mem_cnt >= lat);
      bus.dtr   = bus.ackm ? mem_word(bus.addr) : $urandom;
   endtask

   task automatic set_lat(input int lo, input int hi);
      lat_min = lo;
      lat_max = hi;
      lat     = $urandom_range(hi, lo);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_q.delete();
      xfer_q.delete();
      req2_q.delete();
      acc_cnt = 0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   // Compare process and model update; events happen at the following rising edge.
   always @(negedge clk) begin
      logic exp_ackd, xfer, acc;
      if (reset) begin
         occ      = 0;
         dec_pc   = RV;
         exp_addr = RV;
         out      = 1'b0;
         stale    = 1'b0;
         mem_cnt  = 0;
      end else begin
         exp_ackd = (occ != 0) && !bus.flush;
         chk("ackd", {31'd0, bus.ackd}, {31'd0, exp_ackd});
         if (exp_ackd) begin
            chk("pcd", bus.pcd, dec_pc);
            chk("instd", bus.instd, mem_word(dec_pc));
         end
         if (out) begin
            chk("reqm_hold", {31'd0, bus.reqm}, 32'd1);
            chk("addr_hold", bus.addr, out_addr);
         end else if (bus.reqm) begin
            chk("req_addr", bus.addr, exp_addr);
            chk("req_space", {31'd0, occ < CAP}, 32'd1);
            req_q.push_back(bus.addr);
            out      = 1'b1;
            stale    = 1'b0;
            out_addr = bus.addr;
         end
         if (bus.flush && out) stale = 1'b1;
         xfer = bus.reqd && exp_ackd;
         if (xfer) begin
            xfer_q.push_back(bus.pcd);
            n_xfer++;
         end
         acc = 1'b0;
         if (bus.reqm && bus.ackm && out) begin
            acc = !stale && !bus.flush;
            if (!stale) exp_addr = exp_addr + 32'd4;
            out     = 1'b0;
            mem_cnt = 0;
            lat     = $urandom_range(lat_max, lat_min);
         end else if (bus.reqm) begin
            mem_cnt++;
         end
         if (acc) acc_cnt++;
         if (bus.flush) begin
            occ      = 0;
            dec_pc   = bus.newpc & ~32'h3;
            exp_addr = bus.newpc & ~32'h3;
         end else begin
            occ = occ + int'(acc) - int'(xfer);
            if (xfer) dec_pc = dec_pc + 32'd4;
         end
      end
      if (!reset && bus2.reqm) req2_q.push_back(bus2.addr);
   end

   initial begin
      reset      = 1'b1;
      n_xfer     = 0;
      acc_cnt    = 0;
      mem_cnt    = 0;
      bus.reqd   = 1'b0;
      bus.ackm   = 1'b0;
      bus.dtr    = '0;
      bus.flush  = 1'b0;
      bus.newpc  = '0;
      bus2.reqd  = 1'b1;
      bus2.dtr   = '0;
      bus2.flush = 1'b0;
      bus2.newpc = '0;
      set_lat(1, 1);

      // Reset state, sequential fetch with 1-cycle memory, and wrap from a high reset vector
      bus.reqd = 1'b1;
      do_reset();
      @(negedge clk);
      chk("rst_reqm", {31'd0, bus.reqm}, 32'd0);
      chk("rst_addr", bus.addr, 32'h0000_0100);
      chk("rst_ackd", {31'd0, bus.ackd}, 32'd0);
      chk("rst_instd", bus.instd, 32'd0);
      chk("rst_pcd", bus.pcd, 32'd0);
      for (int i = 0; i < 60 && (xfer_q.size() < 3 || req2_q.size() < 3); i++) tick();
      if (xfer_q.size() < 3 || req_q.size() < 3) fail("t1_seq");
      else begin
         chk("t1_addr0", req_q[0], 32'h0000_0100);
         chk("t1_addr1", req_q[1], 32'h0000_0104);
         chk("t1_addr2", req_q[2], 32'h0000_0108);
         chk("t1_pcd0", xfer_q[0], 32'h0000_0100);
         chk("t1_pcd1", xfer_q[1], 32'h0000_0104);
         chk("t1_pcd2", xfer_q[2], 32'h0000_0108);
      end
      if (req2_q.size() < 3) fail("t5_wrap");
      else begin
         chk("t5_addr0", req2_q[0], 32'hFFFF_FFF8);
         chk("t5_addr1", req2_q[1], 32'hFFFF_FFFC);
         chk("t5_addr2", req2_q[2], 32'h0000_0000);
      end

      // Flush while the request to 0x108 waits for a late acknowledge
      set_lat(3, 3);
      bus.reqd = 1'b1;
      do_reset();
      begin
         bit found = 1'b0;
         for (int i = 0; i < 80 && !found; i++) begin
            tick();
            if (bus.reqm && bus.addr == 32'h108 && mem_cnt == 0) found = 1'b1;
         end
         if (!found) fail("t3_find");
         else begin
            bus.flush = 1'b1;
            bus.newpc = 32'h0000_2002;
            @(negedge clk);
            #1;
            req_q.delete();
            xfer_q.delete();
            for (int i = 0; i < 40 && (req_q.size() < 1 || xfer_q.size() < 1); i++) tick();
            if (req_q.size() < 1 || xfer_q.size() < 1) fail("t3_redirect");
            else begin
               chk("t3_addr", req_q[0], 32'h0000_2000);
               chk("t3_pcd", xfer_q[0], 32'h0000_2000);
            end
         end
      end

      // Decode stalled with zero-wait memory: buffer fills to capacity and requests stop
      set_lat(0, 0);
      bus.reqd = 1'b0;
      do_reset();
      repeat (20) tick();
      @(negedge clk);
      chk("t2_buffered", acc_cnt, CAP);
      chk("t2_reqm", {31'd0, bus.reqm}, 32'd0);
      chk("t2_ackd", {31'd0, bus.ackd}, 32'd1);

      // Flush coinciding with a would-be transfer
      tick();
      bus.flush = 1'b1;
      bus.newpc = 32'h0000_3000;
      bus.reqd  = 1'b1;
      @(negedge clk);
      chk("t4_ackd", {31'd0, bus.ackd}, 32'd0);
      #1;
      xfer_q.delete();
      for (int i = 0; i < 40 && xfer_q.size() < 1; i++) tick();
      if (xfer_q.size() < 1) fail("t4_redirect");
      else chk("t4_pcd", xfer_q[0], 32'h0000_3000);

      // Reset with words buffered and a request outstanding
      set_lat(5, 5);
      bus.reqd = 1'b0;
      do_reset();
      begin
         bit found = 1'b0;
         for (int i = 0; i < 80 && !found; i++) begin
            tick();
            if (occ == T6_OCC && (bus.reqm || CAP == 1)) found = 1'b1;
         end
         if (!found) fail("t6_find");
         else begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clk);
            chk("t6_ackd", {31'd0, bus.ackd}, 32'd0);
            chk("t6_reqm", {31'd0, bus.reqm}, 32'd0);
            chk("t6_pc", bus.addr, 32'h0000_0100);
         end
      end

      // Random traffic: variable memory latency, stalls, redirects and occasional reset
      set_lat(0, 3);
      n_xfer = 0;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] np;
         tick();
         reset    = ($urandom_range(999, 0) < 3);
         bus.reqd = ($urandom_range(99, 0) < 60);
         if ($urandom_range(99, 0) < 4) begin
            np = $urandom;
            if ($urandom_range(3, 0) == 0) np = 32'hFFFF_FFF0 | (np & 32'hF);
            bus.flush = 1'b1;
            bus.newpc = np;
         end
      end
      reset = 1'b0;
      tick();
      @(negedge clk);
      chk("liveness", {31'd0, n_xfer > 300}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
